// File: rtl/sprite_line_scanner_pkg.sv
// Shared definitions for the sprite line scanner: attribute field layout,
// height-code decode and the scanner FSM encoding.
package sprite_line_scanner_pkg;

  localparam int ATTR_W   = 40;
  localparam int X_LSB    = 0;
  localparam int X_MSB    = 9;
  localparam int BPP8_BIT = 12;
  localparam int VFLIP_BIT = 13;
  localparam int HFLIP_BIT = 14;
  localparam int EN_BIT   = 15;
  localparam int Y_LSB    = 16;
  localparam int Y_MSB    = 25;
  localparam int H_LSB    = 26;
  localparam int H_MSB    = 27;
  localparam int W_LSB    = 28;
  localparam int W_MSB    = 29;
  localparam int PIX_LSB  = 30;
  localparam int PIX_MSB  = 39;

  localparam int NUM_SPRITES = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EVAL = 3'd2,
    ST_EMIT = 3'd3,
    ST_END  = 3'd4
  } state_t;

  // Height code to sprite height in lines: 8, 16, 32, 64.
  function automatic logic [6:0] height_lines(input logic [1:0] code);
    case (code)
      2'd0:    height_lines = 7'd8;
      2'd1:    height_lines = 7'd16;
      2'd2:    height_lines = 7'd32;
      default: height_lines = 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/sprite_line_scanner.sv
// Walks all 32 sprite attribute entries once per scanline and streams the
// sprites that cover the requested line to the renderer (valid/ready).
module sprite_line_scanner
  import sprite_line_scanner_pkg::*;
#(
  parameter int MAX_HITS = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              line_start_i,
  input  logic [9:0]        line_i,
  output logic              rd_en_o,
  output logic [4:0]        rd_addr_o,
  input  logic [ATTR_W-1:0] rd_data_i,
  output logic              hit_valid_o,
  input  logic              hit_ready_i,
  output logic [4:0]        hit_idx_o,
  output logic [5:0]        hit_row_o,
  output logic [ATTR_W-1:0] hit_attr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam logic [5:0] HITS_MAX = 6'(MAX_HITS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [9:0]        r_line;
  logic [4:0]        r_idx;
  logic [5:0]        r_hits;
  logic              r_overflow;
  logic [4:0]        r_hit_idx;
  logic [5:0]        r_hit_row;
  logic [ATTR_W-1:0] r_hit_attr;

  logic [9:0]        w_y;
  logic [9:0]        w_diff;
  logic              w_match;
  logic              w_start;
  logic              w_load;
  logic              w_adv;
  logic              w_accept;
  logic              w_set_ovf;

  // Modulo-1024 distance makes sprites wrapping past line 1023 match at the top.
  assign w_y     = rd_data_i[Y_MSB:Y_LSB];
  assign w_diff  = r_line - w_y;
  assign w_match = rd_data_i[EN_BIT] &&
                   (w_diff < {3'b000, height_lines(rd_data_i[H_MSB:H_LSB])});

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_accept    = 1'b0;
    w_set_ovf   = 1'b0;
    if (line_start_i) begin
      // A new line always wins, aborting any scan in flight.
      w_start     = 1'b1;
      w_state_nxt = ST_READ;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_READ: w_state_nxt = ST_EVAL;
        ST_EVAL: begin
          if (w_match) begin
            if (r_hits < HITS_MAX) begin
              w_load      = 1'b1;
              w_state_nxt = ST_EMIT;
            end else begin
              w_set_ovf   = 1'b1;
              w_state_nxt = ST_END;
            end
          end else if (r_idx == 5'd31) begin
            w_state_nxt = ST_END;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_READ;
          end
        end
        ST_EMIT: begin
          if (hit_ready_i) begin
            w_accept = 1'b1;
            if (r_idx == 5'd31) begin
              w_state_nxt = ST_END;
            end else begin
              w_adv       = 1'b1;
              w_state_nxt = ST_READ;
            end
          end
        end
        ST_END:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_line     <= 10'd0;
      r_idx      <= 5'd0;
      r_hits     <= 6'd0;
      r_overflow <= 1'b0;
      r_hit_idx  <= 5'd0;
      r_hit_row  <= 6'd0;
      r_hit_attr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_line     <= line_i;
        r_idx      <= 5'd0;
        r_hits     <= 6'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_adv)     r_idx      <= r_idx + 5'd1;
        if (w_accept)  r_hits     <= r_hits + 6'd1;
        if (w_set_ovf) r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_hit_idx  <= r_idx;
        r_hit_row  <= w_diff[5:0];
        r_hit_attr <= rd_data_i;
      end
    end
  end

  assign rd_en_o     = (r_state == ST_READ);
  assign rd_addr_o   = r_idx;
  assign hit_valid_o = (r_state == ST_EMIT);
  assign hit_idx_o   = r_hit_idx;
  assign hit_row_o   = r_hit_row;
  assign hit_attr_o  = r_hit_attr;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_END);
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with a behavioural attribute RAM.
module tb_sprite_line_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_in = 10'd0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [39:0] rd_data = 40'd0;
  logic        hit_valid;
  logic        hit_ready = 1'b0;
  logic [4:0]  hit_idx;
  logic [5:0]  hit_row;
  logic [39:0] hit_attr;
  logic        busy;
  logic        done;
  logic        overflow;

  logic [39:0] mem [32];

  int checks = 0;
  int errors = 0;

  logic [4:0]  h_idx [$];
  logic [5:0]  h_row [$];
  logic [39:0] h_attr [$];
  int done_cyc;
  int done_cnt;
  int unstable;

  sprite_line_scanner #(.MAX_HITS(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .line_start_i (line_start),
    .line_i       (line_in),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .hit_valid_o  (hit_valid),
    .hit_ready_i  (hit_ready),
    .hit_idx_o    (hit_idx),
    .hit_row_o    (hit_row),
    .hit_attr_o   (hit_attr),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [39:0] mk_attr(input logic [9:0] y, input logic [1:0] hc,
                                          input logic en);
    return {10'h2A5, 2'b01, hc, y, en, 1'b0, 1'b1, 1'b0, 2'b00, 10'h155};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = mk_attr(10'd0, 2'd0, 1'b0);
  endtask

  task automatic start_line(input logic [9:0] l);
    @(negedge clk);
    line_start = 1'b1;
    line_in    = l;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Samples at negedge; cycle 1 is the first cycle after the start pulse.
  task automatic collect(input int ncyc, input int stall);
    int stall_left;
    bit have;
    logic [4:0]  s_idx;
    logic [5:0]  s_row;
    logic [39:0] s_attr;
    h_idx.delete(); h_row.delete(); h_attr.delete();
    done_cyc = -1; done_cnt = 0; unstable = 0;
    stall_left = stall; have = 0;
    s_idx = '0; s_row = '0; s_attr = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (hit_valid) begin
        if (!have) begin
          s_idx = hit_idx; s_row = hit_row; s_attr = hit_attr; have = 1;
        end else if (hit_idx !== s_idx || hit_row !== s_row || hit_attr !== s_attr) begin
          unstable++;
        end
        if (stall_left > 0) begin
          stall_left--;
          hit_ready = 1'b0;
        end else begin
          hit_ready = 1'b1;
          h_idx.push_back(hit_idx);
          h_row.push_back(hit_row);
          h_attr.push_back(hit_attr);
          have = 0;
        end
      end else begin
        hit_ready = 1'b0;
      end
    end
    hit_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, hit_valid, hit_idx, hit_row, hit_attr, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {rd_en, rd_addr, hit_valid, hit_idx, hit_row, hit_attr, busy, done, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    clear_mem();
    mem[1] = mk_attr(10'd123, 2'd0, 1'b1);
    mem[5] = mk_attr(10'd1020, 2'd1, 1'b1);
    start_line(10'd123);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_read: got en=%0b addr=%0d busy=%0b required 1 0 1", rd_en, rd_addr, busy);
    end
    collect(75, 0);
    checks++;
    if (h_idx.size() != 1) begin
      errors++;
      $display("FAIL line123_count: got %0d required 1", h_idx.size());
    end else begin
      checks++;
      if (h_idx[0] !== 5'd1 || h_row[0] !== 6'd0 || h_attr[0] !== mem[1]) begin
        errors++;
        $display("FAIL line123_hit: got idx=%0d row=%0d attr=%h required 1 0 %h",
                 h_idx[0], h_row[0], h_attr[0], mem[1]);
      end
    end
    checks++;
    if (done_cyc != 66 || done_cnt != 1) begin
      errors++;
      $display("FAIL line123_done: got cyc=%0d cnt=%0d required 66 1", done_cyc, done_cnt);
    end
    start_line(10'd130);
    collect(75, 0);
    checks++;
    if (h_idx.size() != 1 || h_row.size() != 1 || h_idx[0] !== 5'd1 || h_row[0] !== 6'd7) begin
      errors++;
      $display("FAIL line130_row: got n=%0d row=%0d required n=1 idx=1 row=7",
               h_idx.size(), (h_row.size() > 0) ? int'(h_row[0]) : -1);
    end
  endtask

  task automatic test_no_hit();
    start_line(10'd131);
    collect(75, 0);
    checks++;
    if (h_idx.size() != 0) begin
      errors++;
      $display("FAIL line131_count: got %0d required 0", h_idx.size());
    end
    checks++;
    if (done_cyc != 65 || done_cnt != 1) begin
      errors++;
      $display("FAIL line131_done: got cyc=%0d cnt=%0d required 65 1", done_cyc, done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_wrap();
    start_line(10'd3);
    collect(75, 0);
    checks++;
    if (h_idx.size() != 1 || h_idx[0] !== 5'd5 || h_row[0] !== 6'd7 || h_attr[0] !== mem[5]) begin
      errors++;
      $display("FAIL wrap_hit: got n=%0d idx=%0d row=%0d required n=1 idx=5 row=7",
               h_idx.size(), (h_idx.size() > 0) ? int'(h_idx[0]) : -1,
               (h_row.size() > 0) ? int'(h_row[0]) : -1);
    end
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < 32; i++) mem[i] = mk_attr(10'd0, 2'd0, 1'b1);
    start_line(10'd0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_at_start: got %0b required 0", overflow);
    end
    collect(60, 0);
    checks++;
    if (h_idx.size() != 16) begin
      errors++;
      $display("FAIL ovf_count: got %0d required 16", h_idx.size());
    end
    bad = 0;
    for (int i = 0; i < h_idx.size(); i++)
      if (h_idx[i] !== 5'(i) || h_row[i] !== 6'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_order: got %0d out-of-order hits required 0", bad);
    end
    checks++;
    if (done_cyc != 51 || done_cnt != 1) begin
      errors++;
      $display("FAIL ovf_done: got cyc=%0d cnt=%0d required 51 1", done_cyc, done_cnt);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b required 1", overflow);
    end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[1] = mk_attr(10'd123, 2'd0, 1'b1);
    start_line(10'd123);
    collect(90, 10);
    checks++;
    if (h_idx.size() != 1 || h_idx[0] !== 5'd1 || h_row[0] !== 6'd0) begin
      errors++;
      $display("FAIL bp_handshakes: got n=%0d required 1 (idx 1 row 0)", h_idx.size());
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes required 0", unstable);
    end
    checks++;
    if (done_cyc != 76 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: got cyc=%0d cnt=%0d required 76 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_abort();
    int pre_hits;
    int pre_done;
    bit found;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = mk_attr(10'd200, 2'd0, 1'b1);
    mem[7] = mk_attr(10'd300, 2'd0, 1'b1);
    start_line(10'd200);
    pre_hits = 0; pre_done = 0; found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (c > 0) @(negedge clk);
      if (done) pre_done++;
      if (hit_valid && hit_idx == 5'd3) begin
        found = 1;
        hit_ready  = 1'b0;
        line_start = 1'b1;
        line_in    = 10'd300;
      end else begin
        hit_ready = hit_valid;
        if (hit_valid) pre_hits++;
      end
    end
    checks++;
    if (!found || pre_hits != 3) begin
      errors++;
      $display("FAIL abort_reach_idx3: got found=%0b prehits=%0d required 1 3", found, pre_hits);
    end
    @(negedge clk);
    line_start = 1'b0;
    checks++;
    if (hit_valid !== 1'b0 || rd_en !== 1'b1 || rd_addr !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: got valid=%0b en=%0b addr=%0d done=%0b required 0 1 0 0",
               hit_valid, rd_en, rd_addr, done);
    end
    collect(75, 0);
    checks++;
    if (h_idx.size() != 1 || h_idx[0] !== 5'd7 || h_row[0] !== 6'd0) begin
      errors++;
      $display("FAIL abort_newline: got n=%0d required 1 hit idx 7 row 0", h_idx.size());
    end
    checks++;
    if (done_cnt + pre_done != 1 || done_cyc != 66) begin
      errors++;
      $display("FAIL abort_done: got cnt=%0d cyc=%0d required 1 66", done_cnt + pre_done, done_cyc);
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 32; i++) mem[i] = mk_attr(10'd0, 2'd0, 1'b1);
    start_line(10'd0);
    collect(20, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, hit_valid, hit_idx, hit_row, hit_attr, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL midscan_reset: got %h required 0",
               {rd_en, rd_addr, hit_valid, hit_idx, hit_row, hit_attr, busy, done, overflow});
    end
    rst_n = 1'b1;
    collect(70, 0);
    checks++;
    if (done_cnt != 0 || h_idx.size() != 0) begin
      errors++;
      $display("FAIL midscan_no_done: got done=%0d hits=%0d required 0 0", done_cnt, h_idx.size());
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single_hit();
    test_no_hit();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_abort();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_scanner.md
# sprite_line_scanner

Per-scanline controller for the 32×40-bit sprite attribute RAM. On each line-start it drives the RAM read port through all 32 entries in index order. It tests each enabled sprite for vertical coverage of the requested line and streams matches to the sprite renderer over a valid/ready interface. It is the sole master of the attribute RAM read port; CPU writes use the RAM write port and do not pass through this block.

## Interface
Parameters:
- MAX_HITS, 16: maximum matches emitted per line (1..32).

Ports:
- clk_i  in  1  single clock; the RAM read port and the renderer share it.
- rst_n_i  in  1  reset, synchronous, active-low.
- line_start_i  in  1  one-cycle pulse that starts a scan.
- line_i  in  10  target line, sampled on line_start_i.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  5  RAM read address.
- rd_data_i  in  40  RAM read data, valid the cycle after rd_en_o.
- hit_valid_o  out  1  match available.
- hit_ready_i  in  1  renderer accepts the match.
- hit_idx_o  out  5  sprite index of the match.
- hit_row_o  out  6  row within the sprite: (line − y) mod 1024.
- hit_attr_o  out  40  raw attribute word.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan end.
- overflow_o  out  1  sticky per line: a match was found after MAX_HITS was reached.

## Operation
- Attribute fields: [9:0] x, [12] 8bpp, [13] vflip, [14] hflip, [15] enable, [25:16] y, [27:26] height code, [29:28] width code, [39:30] pixel address.
- Height code maps to 8 / 16 / 32 / 64 lines.
- Match rule: enable=1 and diff=(line−y) mod 1024 < height. All arithmetic is 10-bit unsigned, so a sprite that wraps past line 1023 matches lines 0.. at the top. hit_row_o = diff[5:0].
- FSM states:
  - IDLE: on line_start_i, latch line, idx=0, hits=0, overflow=0; go to READ.
  - READ: rd_en_o=1, rd_addr_o=idx; go to EVAL.
  - EVAL: evaluate rd_data_i.
    - Match and hits<MAX_HITS: load the output register and go to EMIT.
    - Match and hits=MAX_HITS: set overflow, go to END.
    - No match: idx==31 goes to END, otherwise idx+1 and READ.
  - EMIT: hold hit_valid_o until hit_ready_i. On accept, hits+1, then idx==31 goes to END, otherwise idx+1 and READ.
  - END: done_o=1 for one cycle, go to IDLE.
- When hits reaches MAX_HITS, scanning continues only to detect overflow; it ends at the first further match.
- line_start_i in any non-IDLE state aborts the scan:
  - Restart at idx 0 with the new line; hits and overflow are cleared.
  - No done_o for the aborted scan.
  - A pending hit_valid_o is dropped.
- The attribute RAM is read live, so a CPU write during a scan affects only entries not yet read.

## Timing
- Reset values: rd_en_o=0, rd_addr_o=0, hit_valid_o=0, hit_idx_o=0, hit_row_o=0, hit_attr_o=0, busy_o=0, done_o=0, overflow_o=0. FSM is in IDLE.
- A scan starting at line_start_i in cycle t gives READ at t+1 and the first EVAL at t+2.
- A non-matching entry costs 2 cycles. A match costs 2 cycles plus the EMIT wait (minimum 1).
- A full scan with no matches: done_o at t+65.
- hit_* outputs are registered and stable while hit_valid_o=1 && !hit_ready_i.
- hit_valid_o never depends combinationally on hit_ready_i.
- busy_o is 1 in READ, EVAL, EMIT and END.
- overflow_o holds until the next line_start_i.

## Structure
- Shared package: attribute field bit positions, the height-code decode function, and FSM state encoding.
- No sub-module is needed; the height decode stays a package function.

## Test plan
- Entry 1: y=123, enable, height 8. All other entries disabled. Line 123 gives one hit (idx=1, row=0). Line 130 gives row=7. Line 131 gives no hit. done_o at t+65 when there is no hit.
- Entry 5: y=1020, height code 1 (16 lines). Line 3 gives a hit with row=7, exercising wrap-around.
- All 32 entries enabled with y=0, height 8, MAX_HITS=16. Line 0 gives idx 0..15 in order, overflow_o=1 after idx 16 is evaluated, then done_o.
- Same as the single-hit case with hit_ready_i held low 10 cycles. hit_* stays stable, exactly one handshake occurs, and hits do not duplicate.
- line_start_i during EMIT of idx 3. The pending hit is dropped, the scan restarts at idx 0 with the new line, and done_o pulses once.
- rst_n_i low mid-scan. On the next cycle all outputs are at reset values, and there is no done_o.
